// File: rtl/bfu_twiddle_mult_if.sv
// Handshake and data bundle for the twiddle multiplier: input beat (XA, XB, W) and
// output beat (XA aligned with P = XB*W, plus saturation flag).
interface bfu_twiddle_mult_if #(
   parameter int unsigned DW = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] Xar;
   logic signed [DW-1:0] Xai;
   logic signed [DW-1:0] Xbr;
   logic signed [DW-1:0] Xbi;
   logic signed [DW-1:0] Wr;
   logic signed [DW-1:0] Wi;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] Xar_o;
   logic signed [DW-1:0] Xai_o;
   logic signed [DW-1:0] Pr;
   logic signed [DW-1:0] Pi;
   logic                 sat;

   modport master (
      output in_valid, Xar, Xai, Xbr, Xbi, Wr, Wi, out_ready,
      input  in_ready, out_valid, Xar_o, Xai_o, Pr, Pi, sat
   );

   modport slave (
      input  in_valid, Xar, Xai, Xbr, Xbi, Wr, Wi, out_ready,
      output in_ready, out_valid, Xar_o, Xai_o, Pr, Pi, sat
   );
endinterface

// File: rtl/bfu_twiddle_mult.sv
// Three-stage pipelined complex multiply P = XB*W (fixed point, round half-up, saturating)
// with XA carried alongside so both reach the butterfly adder on the same cycle.
module bfu_twiddle_mult #(
   parameter int unsigned DW   = 16,
   parameter int unsigned FRAC = 14,
   parameter int unsigned LAT  = 3
) (
   input logic              clk,
   input logic              rst_n,
   bfu_twiddle_mult_if.slave bus
);

   localparam int unsigned PW = 2 * DW;
   localparam int unsigned SW = 2 * DW + 1;

   localparam logic signed [SW-1:0] RndBias = SW'(1) << (FRAC - 1);
   localparam logic signed [SW-1:0] MaxVal  = (SW'(1) << (DW - 1)) - SW'(1);
   localparam logic signed [SW-1:0] MinVal  = SW'(0) - (SW'(1) << (DW - 1));

   // LAT sizes the valid pipe only; the datapath below is fixed at three register stages.
   logic [LAT-1:0] vld_q;
   logic           adv;

   logic signed [DW-1:0] xar1_q, xai1_q, xbr1_q, xbi1_q, wr1_q, wi1_q;
   logic signed [DW-1:0] xar2_q, xai2_q;
   logic signed [PW-1:0] prr2_q, pii2_q, pri2_q, pir2_q;
   logic signed [DW-1:0] xar3_q, xai3_q, pr3_q, pi3_q;
   logic                 sat3_q;

   logic signed [SW-1:0] sr, si, sr_sh, si_sh;
   logic signed [DW-1:0] pr_d, pi_d;
   logic                 sat_d;

   assign adv          = bus.out_ready | ~vld_q[LAT-1];
   assign bus.in_ready = adv;

   always_comb begin
      sr    = SW'(prr2_q) - SW'(pii2_q);
      si    = SW'(pri2_q) + SW'(pir2_q);
      sr_sh = (sr + RndBias) >>> FRAC;
      si_sh = (si + RndBias) >>> FRAC;
      pr_d  = sr_sh[DW-1:0];
      pi_d  = si_sh[DW-1:0];
      sat_d = 1'b0;
      if (sr_sh > MaxVal) begin
         pr_d  = MaxVal[DW-1:0];
         sat_d = 1'b1;
      end else if (sr_sh < MinVal) begin
         pr_d  = MinVal[DW-1:0];
         sat_d = 1'b1;
      end
      if (si_sh > MaxVal) begin
         pi_d  = MaxVal[DW-1:0];
         sat_d = 1'b1;
      end else if (si_sh < MinVal) begin
         pi_d  = MinVal[DW-1:0];
         sat_d = 1'b1;
      end
   end

   // A single advance enable freezes every stage, so stalls add latency one-for-one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         xar1_q <= '0;
         xai1_q <= '0;
         xbr1_q <= '0;
         xbi1_q <= '0;
         wr1_q  <= '0;
         wi1_q  <= '0;
         xar2_q <= '0;
         xai2_q <= '0;
         prr2_q <= '0;
         pii2_q <= '0;
         pri2_q <= '0;
         pir2_q <= '0;
         xar3_q <= '0;
         xai3_q <= '0;
         pr3_q  <= '0;
         pi3_q  <= '0;
         sat3_q <= 1'b0;
      end else if (adv) begin
         vld_q  <= {vld_q[LAT-2:0], bus.in_valid};
         xar1_q <= bus.Xar;
         xai1_q <= bus.Xai;
         xbr1_q <= bus.Xbr;
         xbi1_q <= bus.Xbi;
         wr1_q  <= bus.Wr;
         wi1_q  <= bus.Wi;
         xar2_q <= xar1_q;
         xai2_q <= xai1_q;
         prr2_q <= PW'(xbr1_q) * PW'(wr1_q);
         pii2_q <= PW'(xbi1_q) * PW'(wi1_q);
         pri2_q <= PW'(xbr1_q) * PW'(wi1_q);
         pir2_q <= PW'(xbi1_q) * PW'(wr1_q);
         xar3_q <= xar2_q;
         xai3_q <= xai2_q;
         pr3_q  <= pr_d;
         pi3_q  <= pi_d;
         sat3_q <= sat_d;
      end
   end

   assign bus.out_valid = vld_q[LAT-1];
   assign bus.Xar_o     = xar3_q;
   assign bus.Xai_o     = xai3_q;
   assign bus.Pr        = pr3_q;
   assign bus.Pi        = pi3_q;
   assign bus.sat       = sat3_q;

endmodule

// File: tb/tb_bfu_twiddle_mult.sv
// Scoreboard bench for bfu_twiddle_mult: directed vectors, back-pressure, random traffic
// and mid-flight reset, checked against an arithmetic reference model.
module tb_bfu_twiddle_mult;

   typedef struct {
      logic signed [15:0] xar, xai, xbr, xbi, wr, wi;
   } beat_t;

   typedef struct {
      logic signed [15:0] xar, xai, pr, pi;
      logic               sat;
      int                 acc_cyc;
      int                 acc_stall;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   stall_cnt = 0;
   int   last_emit = 0;
   int   bp_mode = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bfu_twiddle_mult_if #(.DW(16)) bus ();

   bfu_twiddle_mult #(.DW(16), .FRAC(14), .LAT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // floor((v + 2^13) / 2^14) with explicit floor for negatives
   function automatic longint scale(input longint v);
      longint t = v + 8192;
      if (t >= 0) return t / 16384;
      return -((-t + 16383) / 16384);
   endfunction

   function automatic longint clip(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic exp_t model(input beat_t b);
      exp_t   e;
      longint r = scale(longint'(b.xbr) * b.wr - longint'(b.xbi) * b.wi);
      longint i = scale(longint'(b.xbr) * b.wi + longint'(b.xbi) * b.wr);
      e.xar = b.xar;
      e.xai = b.xai;
      e.pr  = 16'(clip(r));
      e.pi  = 16'(clip(i));
      e.sat = (clip(r) != r) || (clip(i) != i);
      e.acc_cyc = 0;
      e.acc_stall = 0;
      return e;
   endfunction

   function automatic logic signed [15:0] rv();
      case ($urandom_range(0, 6))
         0:       return -16'sd32768;
         1:       return 16'sd32767;
         2:       return 16'sd16384;
         3:       return -16'sd16384;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic send(input beat_t b, output int acc);
      exp_t e;
      bit   rdy;
      int   g = 0;
      int   st = 0;
      bus.in_valid = 1'b1;
      bus.Xar = b.xar;
      bus.Xai = b.xai;
      bus.Xbr = b.xbr;
      bus.Xbi = b.xbi;
      bus.Wr  = b.wr;
      bus.Wi  = b.wi;
      acc = 0;
      do begin
         @(negedge clk);
         rdy = bus.in_ready;
         st  = stall_cnt;
         acc = cyc;
         @(posedge clk);
         g++;
      end while (!rdy && g < 200);
      if (!rdy) check("accept_timeout", 0, 1);
      else begin
         e = model(b);
         e.acc_cyc = acc;
         e.acc_stall = st;
         sb.push_back(e);
      end
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 500) begin
         @(posedge clk);
         g++;
      end
      #1 check("drain_queue_empty", sb.size(), 0);
   endtask

   task automatic ready_drv();
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: bus.out_ready = 1'b0;
         endcase
      end
   endtask

   task automatic monitor();
      exp_t               e;
      logic signed [15:0] h_pr, h_pi, h_xr, h_xi;
      logic               h_sat;
      bit                 held = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 0;
            continue;
         end
         if (held) begin
            check("hold_p", {bus.Pr, bus.Pi}, {h_pr, h_pi});
            check("hold_xa_sat", {bus.Xar_o, bus.Xai_o, bus.sat}, {h_xr, h_xi, h_sat});
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) check("unexpected_beat", 1, 0);
            else begin
               e = sb.pop_front();
               check("Pr", bus.Pr, e.pr);
               check("Pi", bus.Pi, e.pi);
               check("Xar_o", bus.Xar_o, e.xar);
               check("Xai_o", bus.Xai_o, e.xai);
               check("sat", bus.sat, e.sat);
               check("latency", cyc - e.acc_cyc, 3 + stall_cnt - e.acc_stall);
               last_emit = cyc;
            end
         end
         held = bus.out_valid && !bus.out_ready;
         if (held) begin
            stall_cnt++;
            h_pr = bus.Pr;
            h_pi = bus.Pi;
            h_xr = bus.Xar_o;
            h_xi = bus.Xai_o;
            h_sat = bus.sat;
         end
      end
   endtask

   initial begin
      beat_t b;
      int    acc, first_acc;
      beat_t dir[7];
      dir[0] = '{16'sd8192, -16'sd8192, 16'sd16384, 16'sd0, 16'sd16384, 16'sd0};
      dir[1] = '{16'sd100, 16'sd200, 16'sd16384, 16'sd8192, 16'sd0, -16'sd16384};
      dir[2] = '{16'sd1, 16'sd2, 16'sd1, 16'sd0, 16'sd8192, 16'sd0};
      dir[3] = '{16'sd3, 16'sd4, 16'sd1, 16'sd0, 16'sd8191, 16'sd0};
      dir[4] = '{16'sd5, 16'sd6, -16'sd1, 16'sd0, 16'sd8192, 16'sd0};
      dir[5] = '{16'sd7, 16'sd8, 16'sd32767, 16'sd32767, 16'sd32767, -16'sd32767};
      dir[6] = '{16'sd9, 16'sd10, 16'sd32767, 16'sd32767, -16'sd32767, 16'sd32767};
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      {bus.Xar, bus.Xai, bus.Xbr, bus.Xbi, bus.Wr, bus.Wi} = '0;
      fork
         monitor();
         ready_drv();
         begin
            #2_000_000;
            $display("FAIL watchdog: simulation did not finish");
            $fatal(1);
         end
      join_none

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_P", {bus.Pr, bus.Pi}, 0);
      check("reset_Xa_sat", {bus.Xar_o, bus.Xai_o, bus.sat}, 0);
      @(negedge clk) rst_n = 1'b1;
      #1 check("in_ready_after_reset", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // directed vectors, spaced so latency is exactly 3
      for (int k = 0; k < 7; k++) begin
         send(dir[k], acc);
         idle(4);
      end
      drain();

      // back-pressure: 8 beats back to back with a 4-cycle out_ready drop
      first_acc = 0;
      fork
         for (int k = 1; k <= 8; k++) begin
            b = '{16'($urandom), 16'($urandom), 16'(k * 1024), 16'sd0, 16'sd16384, 16'sd0};
            send(b, acc);
            if (k == 1) first_acc = acc;
         end
         begin
            int g = 0;
            int low = 0;
            do begin
               @(negedge clk);
               g++;
            end while (!bus.out_valid && g < 50);
            check("bp_first_valid_seen", bus.out_valid, 1);
            bp_mode = 2;
            repeat (4) begin
               @(negedge clk);
               if (!bus.in_ready) low++;
            end
            bp_mode = 0;
            check("bp_in_ready_low_cycles", low, 4);
         end
      join
      drain();
      check("bp_total_cycles", last_emit - first_acc + 1, 8 + 3 + 4);
      idle(2);

      // random traffic with random bubbles and back-pressure
      bp_mode = 1;
      for (int k = 0; k < 80; k++) begin
         b = '{rv(), rv(), rv(), rv(), rv(), rv()};
         send(b, acc);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      bp_mode = 0;
      drain();
      idle(2);

      // reset with three beats in flight
      for (int k = 0; k < 3; k++) begin
         b = '{16'sd1000, 16'sd2000, rv(), rv(), rv(), rv()};
         send(b, acc);
      end
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", bus.out_valid, 0);
      check("midreset_P", {bus.Pr, bus.Pi}, 0);
      check("midreset_Xa_sat", {bus.Xar_o, bus.Xai_o, bus.sat}, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_reset_no_stale", bus.out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(dir[0], acc);
      drain();
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
